// File: rtl/sign_matched_filter_pkg.sv
// Shared constants and helpers for the sign-coefficient matched filter.
package sign_matched_filter_pkg;
  localparam int IN_W          = 16;
  localparam int NUM_TAPS      = 96;
  localparam int ACC_W         = 24;
  localparam int TAPS_PER_WORD = 16;
  localparam int NUM_WORDS     = NUM_TAPS / TAPS_PER_WORD;
  localparam int FILL_W        = 7;

  localparam logic [2:0] CS_COEF_FIRST = 3'd1;
  localparam logic [2:0] CS_COEF_LAST  = 3'd6;
  localparam logic [2:0] CS_THRESH     = 3'd7;

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NUM_TAPS);

  // The most negative accumulator value is unreachable, so the negation never wraps.
  function automatic logic [ACC_W-1:0] mag(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? ACC_W'(-v) : ACC_W'(v);
  endfunction
endpackage

// File: rtl/mf_sign_accum.sv
// Combinational sign-controlled adder tree: correlates the delay line against +-1/+-j taps.
module mf_sign_accum
  import sign_matched_filter_pkg::*;
(
  input  logic [NUM_TAPS*2*IN_W-1:0] i_line,
  input  logic [2*NUM_TAPS-1:0]      i_coef,
  output logic signed [ACC_W-1:0]    o_re,
  output logic signed [ACC_W-1:0]    o_im
);
  always_comb begin
    logic signed [ACC_W-1:0] v_xr;
    logic signed [ACC_W-1:0] v_xi;
    o_re = '0;
    o_im = '0;
    v_xr = '0;
    v_xi = '0;
    // Tap k occupies line bits [32k +: 32] as {re, im}; coef bit 2k+1 is cr, 2k is ci.
    for (int k = 0; k < NUM_TAPS; k++) begin
      v_xr = ACC_W'($signed(i_line[k*2*IN_W+IN_W +: IN_W]));
      v_xi = ACC_W'($signed(i_line[k*2*IN_W +: IN_W]));
      o_re = i_coef[2*k+1] ? o_re - v_xr : o_re + v_xr;
      o_re = i_coef[2*k]   ? o_re - v_xi : o_re + v_xi;
      o_im = i_coef[2*k+1] ? o_im - v_xi : o_im + v_xi;
      o_im = i_coef[2*k]   ? o_im + v_xr : o_im - v_xr;
    end
  end
endmodule

// File: rtl/strobe_gen.sv
// Rate source: one strobe every rate+1 enabled clocks (instantiated beside the filter).
module strobe_gen (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       strobe_in,
  input  logic [7:0] rate,
  output logic       strobe
);
  logic [7:0] r_counter;

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      r_counter <= 8'd0;
    end else if (strobe_in) begin
      r_counter <= (r_counter == 8'd0) ? rate : r_counter - 8'd1;
    end
  end

  assign strobe = !reset && enable && strobe_in && (r_counter == 8'd0);
endmodule

// File: rtl/sign_matched_filter.sv
// Complex sign-coefficient correlator with programmable taps and match threshold.
module sign_matched_filter
  import sign_matched_filter_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] r_input,
  input  logic [IN_W-1:0] i_input,
  input  logic            rxstrobe,
  input  logic [31:0]     cdata,
  input  logic [2:0]      cstate,
  input  logic            cwrite,
  output logic            valid,
  output logic            match
);
  logic [NUM_TAPS*2*IN_W-1:0] r_line;
  logic [2*NUM_TAPS-1:0]      r_coef;
  logic [31:0]                r_thresh;
  logic                       r_armed;
  logic [FILL_W-1:0]          r_fill;
  logic                       r_strobe_d;

  logic signed [ACC_W-1:0]    w_re;
  logic signed [ACC_W-1:0]    w_im;
  logic [31:0]                w_metric;
  logic                       w_go;

  mf_sign_accum u_accum (
    .i_line (r_line),
    .i_coef (r_coef),
    .o_re   (w_re),
    .o_im   (w_im)
  );

  assign w_metric = 32'(mag(w_re)) + 32'(mag(w_im));
  assign w_go     = r_strobe_d && r_armed && (r_fill == FILL_FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_line     <= '0;
      r_fill     <= '0;
      r_strobe_d <= 1'b0;
    end else begin
      r_strobe_d <= rxstrobe;
      if (rxstrobe) begin
        r_line <= {r_line[NUM_TAPS*2*IN_W-2*IN_W-1:0], r_input, i_input};
        if (r_fill != FILL_FULL) r_fill <= r_fill + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_coef   <= '0;
      r_thresh <= '0;
      r_armed  <= 1'b0;
    end else if (cwrite) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        if (cstate == CS_COEF_FIRST + 3'(w)) r_coef[32*w +: 32] <= cdata;
      end
      if (cstate == CS_THRESH) begin
        r_thresh <= cdata;
        r_armed  <= 1'b1;
      end
    end
  end

  // valid is a single-cycle pulse with no back-pressure; match is only ever high alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      match <= 1'b0;
    end else begin
      valid <= w_go;
      match <= w_go && (w_metric > r_thresh);
    end
  end
endmodule

// File: tb/tb_sign_matched_filter.sv
// Randomized scoreboard bench for sign_matched_filter with an arithmetic reference model.
module tb_sign_matched_filter;
  import sign_matched_filter_pkg::*;

  localparam int W = 33;

  logic        clk;
  logic        reset;
  logic [15:0] r_input;
  logic [15:0] i_input;
  logic        tb_strobe;
  logic        rxstrobe;
  logic [31:0] cdata;
  logic [2:0]  cstate;
  logic        cwrite;
  logic        valid;
  logic        match;
  logic        gen_mode;
  logic [7:0]  gen_rate;
  logic        w_gen_strobe;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int last_valid = 0;
  bit chk_period = 0;

  // Scoreboard entries: {due cycle[32:1], expected match[0]}
  logic [W-1:0] exp_q[$];

  // Reference model state
  int          m_xr[NUM_TAPS];
  int          m_xi[NUM_TAPS];
  logic [31:0] m_coef[6];
  logic [31:0] m_thr;
  bit          m_armed;
  int          m_fill;

  assign rxstrobe = gen_mode ? w_gen_strobe : tb_strobe;

  strobe_gen u_gen (
    .clock     (clk),
    .reset     (~reset),
    .enable    (gen_mode),
    .strobe_in (1'b1),
    .rate      (gen_rate),
    .strobe    (w_gen_strobe)
  );

  sign_matched_filter dut (
    .clk      (clk),
    .reset    (reset),
    .r_input  (r_input),
    .i_input  (i_input),
    .rxstrobe (rxstrobe),
    .cdata    (cdata),
    .cstate   (cstate),
    .cwrite   (cwrite),
    .valid    (valid),
    .match    (match)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic void model_reset();
    for (int k = 0; k < NUM_TAPS; k++) begin
      m_xr[k] = 0;
      m_xi[k] = 0;
    end
    for (int w = 0; w < 6; w++) m_coef[w] = '0;
    m_thr   = '0;
    m_armed = 0;
    m_fill  = 0;
  endfunction

  function automatic longint model_metric();
    longint re = 0;
    longint im = 0;
    int cr, ci;
    for (int k = 0; k < NUM_TAPS; k++) begin
      cr = m_coef[k / 16][2 * (k % 16) + 1] ? -1 : 1;
      ci = m_coef[k / 16][2 * (k % 16)]     ? -1 : 1;
      re += cr * m_xr[k] + ci * m_xi[k];
      im += cr * m_xi[k] - ci * m_xr[k];
    end
    if (re < 0) re = -re;
    if (im < 0) im = -im;
    return re + im;
  endfunction

  function automatic void model_apply(input bit stb, input int r, input int i,
                                      input bit cw, input logic [2:0] cs, input logic [31:0] cd);
    logic [15:0] rv;
    logic [15:0] iv;
    longint met;
    if (cw) begin
      if (cs >= 3'd1 && cs <= 3'd6) m_coef[cs - 3'd1] = cd;
      if (cs == 3'd7) begin
        m_thr   = cd;
        m_armed = 1;
      end
    end
    if (stb) begin
      rv = 16'(r);
      iv = 16'(i);
      for (int k = NUM_TAPS - 1; k > 0; k--) begin
        m_xr[k] = m_xr[k-1];
        m_xi[k] = m_xi[k-1];
      end
      m_xr[0] = int'($signed(rv));
      m_xi[0] = int'($signed(iv));
      if (m_fill < NUM_TAPS) m_fill++;
      if (m_armed && m_fill == NUM_TAPS) begin
        met = model_metric();
        exp_q.push_back({32'(cyc + 2), (met > longint'(m_thr))});
      end
    end
  endfunction

  // Driver tasks: called at a negedge, drive for one cycle, return at the next negedge.
  task automatic step(input bit stb, input int r, input int i,
                      input bit cw, input logic [2:0] cs, input logic [31:0] cd);
    tb_strobe = stb;
    r_input   = 16'(r);
    i_input   = 16'(i);
    cwrite    = cw;
    cstate    = cs;
    cdata     = cd;
    if (reset) model_apply(stb, r, i, cw, cs, cd);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 3'd0, 32'd0);
  endtask

  task automatic write_ctrl(input logic [2:0] cs, input logic [31:0] cd);
    step(0, 0, 0, 1, cs, cd);
  endtask

  task automatic write_all_coef(input logic [31:0] cd);
    for (int w = 1; w <= 6; w++) write_ctrl(3'(w), cd);
  endtask

  task automatic strobe_n(input int n, input int r, input int i, input int max_gap);
    for (int k = 0; k < n; k++) begin
      step(1, r, i, 0, 3'd0, 32'd0);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  function automatic int rand_s16();
    return int'($signed(16'($urandom)));
  endfunction

  // Monitor / scoreboard
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    while (exp_q.size() != 0 && int'(exp_q[0][32:1]) < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_valid: no valid at cycle %0d (expected match=%0b)", e[32:1], e[0]);
    end
    if (!valid) begin
      checks++;
      if (match !== 1'b0) begin
        errors++;
        $display("FAIL match_without_valid cyc=%0d: match=%b required 0", cyc, match);
      end
    end else begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid cyc=%0d: valid=1 match=%b, required no result", cyc, match);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (int'(e[32:1]) != cyc || e[0] !== match) begin
          errors++;
          $display("FAIL result cyc=%0d: match=%b, required match=%b at cycle %0d",
                   cyc, match, e[0], e[32:1]);
        end
      end
      if (chk_period && last_valid != 0) begin
        checks++;
        if (cyc - last_valid != 17) begin
          errors++;
          $display("FAIL strobe_period: valid spacing %0d clks, required 17", cyc - last_valid);
        end
      end
      last_valid = cyc;
    end
  end

  // Stimulus
  initial begin
    int scnt;
    bit stb;
    reset     = 1'b0;
    gen_mode  = 1'b0;
    gen_rate  = 8'd16;
    tb_strobe = 1'b0;
    r_input   = '0;
    i_input   = '0;
    cwrite    = 1'b0;
    cstate    = '0;
    cdata     = '0;
    model_reset();
    repeat (3) @(negedge clk);

    // Activity while held in reset must produce nothing
    for (int k = 0; k < 12; k++) begin
      step($urandom_range(0, 1), rand_s16(), rand_s16(), $urandom_range(0, 1),
           3'($urandom_range(0, 7)), $urandom);
      checks++;
      if (valid !== 1'b0 || match !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: valid=%b match=%b, required 0/0", valid, match);
      end
    end
    reset = 1'b1;
    idle(2);

    // All +1+j taps, fill without valid until the 96th strobe after arming
    write_all_coef(32'h0000_0000);
    strobe_n(95, 100, 0, 2);
    write_ctrl(CS_THRESH, 32'd1000);
    strobe_n(1, 100, 0, 0);
    idle(3);

    // Threshold boundaries around metric 19200
    write_ctrl(CS_THRESH, 32'd20000);
    strobe_n(5, 100, 0, 1);
    write_ctrl(CS_THRESH, 32'd19200);
    strobe_n(3, 100, 0, 0);
    write_ctrl(CS_THRESH, 32'd19199);
    strobe_n(2, 100, 0, 1);

    // Negative input, back-to-back strobes
    write_ctrl(CS_THRESH, 32'd1000);
    strobe_n(96, -100, 0, 0);
    idle(3);

    // Alternating taps: constant input cancels, alternating input aligns
    write_all_coef(32'h3333_3333);
    strobe_n(96, 100, 0, 0);
    for (int k = 0; k < 100; k++) step(1, (k % 2) ? 100 : -100, 0, 0, 3'd0, 32'd0);
    idle(3);

    // Random coefficients, samples, thresholds and simultaneous writes
    for (int k = 0; k < 200; k++) begin
      if (k % 40 == 0) begin
        for (int w = 1; w <= 6; w++) write_ctrl(3'(w), $urandom);
        write_ctrl(CS_THRESH, $urandom_range(0, 700000));
      end
      if ($urandom_range(0, 7) == 0)
        step(1, rand_s16(), rand_s16(), 1, 3'($urandom_range(0, 7)), $urandom_range(0, 700000));
      else
        step(1, rand_s16(), rand_s16(), 0, 3'd0, 32'd0);
      idle($urandom_range(0, 1));
    end
    idle(3);

    // Reset mid-operation: must re-arm and refill before any result
    reset = 1'b0;
    model_reset();
    idle(2);
    reset = 1'b1;
    idle(1);
    for (int w = 1; w <= 6; w++) write_ctrl(3'(w), $urandom);
    strobe_n(100, 300, -200, 0);
    step(1, 250, 125, 1, CS_THRESH, 32'd0);
    strobe_n(4, 90, -30, 1);
    idle(3);

    // Rate source drives the strobe; a threshold write lands with the 10th strobe
    write_ctrl(CS_THRESH, 32'hFFFF_FFFF);
    idle(3);
    chk_period = 1;
    last_valid = 0;
    gen_mode   = 1'b1;
    #1;
    scnt = 0;
    for (int c = 0; c < 30 * 17; c++) begin
      stb = w_gen_strobe;
      if (stb) scnt++;
      if (stb && scnt == 10)
        step(1, rand_s16(), rand_s16(), 1, CS_THRESH, 32'd0);
      else
        step(stb, rand_s16(), rand_s16(), 0, 3'd0, 32'd0);
    end
    gen_mode = 1'b0;
    idle(4);
    chk_period = 0;

    idle(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results: %0d expected results never appeared, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sign_matched_filter.md
Name: sign_matched_filter

Overview:
Complex sign-coefficient matched filter (correlator) on the RX sample path. Captures I/Q samples on each rx strobe and correlates the newest NUM_TAPS samples against a programmable ±1/±j tap pattern. Issues a per-sample valid pulse and a match flag when the correlation magnitude exceeds a programmable threshold. Coefficients and threshold load through a small cstate/cdata/cwrite control port.

Parameters:
IN_W, 16, I/Q sample width (signed two's complement)
NUM_TAPS, 96, correlator length; fixed at 6 coefficient words × 16 taps
ACC_W, 24, signed accumulator width (IN_W + 1 + ceil(log2(NUM_TAPS)))

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
r_input  in  16  real (I) sample, signed
i_input  in  16  imaginary (Q) sample, signed
rxstrobe  in  1  one-clk pulse, sample inputs valid
cdata  in  32  control write data
cstate  in  3  control word address
cwrite  in  1  control write enable
valid  out  1  one-clk pulse, new correlation result
match  out  1  correlation metric > threshold, qualified by valid

Behaviour:
- Reset (reset=0, async): delay line, coefficients, threshold, fill counter, armed flag and both outputs cleared to 0.
- Control writes, sampled at the clk edge when cwrite=1:
  - cstate 1..6: load coefficient word cstate-1.
    - Bits [2j+1:2j] are tap 16*(cstate-1)+j.
    - Bit 2j+1 is the real sign cr, bit 2j is the imag sign ci; 0 = +1, 1 = -1.
  - cstate 7: load 32-bit unsigned threshold and set armed = 1.
  - cstate 0: no effect.
  - A write takes effect from the next clk.
  - A write does not disturb the delay line.
- Delay line:
  - On rxstrobe=1, shift {r_input, i_input} into tap 0; older samples move up one tap; the oldest is discarded.
  - Inputs are ignored when rxstrobe=0.
  - Fill counter increments per strobe and saturates at NUM_TAPS.
- Correlation, tap k against sample x[k] (x[0] newest):
  - re = Σ(cr·xr + ci·xi)
  - im = Σ(cr·xi − ci·xr)
  - Each term is a sign-controlled add or subtract; no multipliers. Accumulate in ACC_W signed bits; no overflow is possible.
  - metric = |re| + |im|, unsigned, zero-extended to 32 bits. Abs of the most negative value cannot occur at these widths.
- Timing:
  - Strobe captured at edge t.
  - Correlation over the updated delay line registered at edge t+1.
  - valid = 1 for exactly one clk after edge t+1.
  - match is registered together with valid: match = valid & (metric > threshold). Comparison is strict.
  - match is never 1 while valid = 0.
- Gating:
  - valid is asserted only when armed = 1 and fill counter = NUM_TAPS, i.e. the strobe that made the counter reach NUM_TAPS or a later one.
  - Strobes before that update the delay line silently.
- Simultaneous cwrite and rxstrobe: both act. The result of that strobe uses the coefficient/threshold values as of edge t+1, including the new write.
- Strobes on consecutive clks: each produces its own valid pulse.
- Reset mid-operation: everything clears. Coefficients must be reloaded and the line refilled (NUM_TAPS strobes) before the next valid.

Decomposition:
- Shared package: IN_W, NUM_TAPS, ACC_W, TAPS_PER_WORD=16, cstate codes CS_COEF_FIRST=1, CS_COEF_LAST=6, CS_THRESH=7.
- Natural sub-module: mf_sign_accum, the combinational sign-controlled adder tree producing re/im from the delay line and coefficient bits.
- The existing strobe_gen (ports reset, enable, clock, strobe_in, strobe, rate[7:0]) is the rate source, instantiated beside the block, not inside it.
  - Issues one strobe every rate+1 enabled clks.
  - rate=16 gives one strobe per 17 clks.

Test Plan:
- Reset: hold reset=0, toggle inputs and strobes -> valid=0, match=0; after release, no valid before armed and NUM_TAPS strobes.
- Coefficient words 1..6 = 0x00000000 (all +1+j), threshold 1000; feed r=100, i=0 -> strobes 1..95 no valid; 96th strobe gives valid 2 clks after its edge; re=9600, im=−9600, metric=19200, match=1.
- Same setup, threshold=20000 -> valid pulses every strobe, match=0; threshold=19200 -> match=0 (strict).
- Inputs r=−100, i=0 -> metric 19200, match=1 (magnitude insensitive to sign).
- Coefficient words 0x33333333 (taps alternate +1+j / −1−j), constant input r=100 -> re=im=0, match=0; then a ±100 input aligned with the pattern -> metric 19200, match=1.
- Rate: strobe_gen rate=16 drives rxstrobe -> exactly one valid per 17 clks after fill; cwrite cstate 7 in the same clk as a strobe -> that strobe's result uses the new threshold.
